cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Run/halt/single-step sequencer for the single-cycle CPU on the board. Replaces the fixed
//   divided CPU clock with a one-cycle clock-enable pulse (cpu_en) on the board clock.
//   Modes: free-run at a divided rate, halted, or one instruction per debounced button press.
//   Also keeps a retired-cycle count for the seven-segment display.
// PARAMETERS
//   RUN_DIV     500000   clk cycles per cpu_en pulse in RUN (>=2)
//   DEB_CYCLES  1000000  consecutive stable clk cycles before step_btn's debounced level changes (>=1)
//   CNT_W       32       width of cycle_cnt
// PORTS
//   clk        in   1      board clock, all flops rising-edge
//   rst        in   1      asynchronous, active-high reset
//   halt       in   1      raw switch; 1 forces HALT
//   step_mode  in   1      raw switch; 1 = single-step mode, 0 = free-run
//   step_btn   in   1      raw, bouncing push-button
//   cpu_en     out  1      one-clk clock-enable pulse to CPU
//   cpu_halted out  1      1 while state == HALT
//   state      out  2      HALT=00 RUN=01 STEP_WAIT=10 STEP_FIRE=11
//   cycle_cnt  out  CNT_W  number of cpu_en pulses since reset
// BEHAVIOUR
//   Reset (async): state=HALT, cpu_en=0, cpu_halted=1, cycle_cnt=0, div_cnt=0.
//     Debounce counter=0, debounced level=0, synchronisers=0. cpu_en drops with no clock edge.
//   Inputs: each of halt/step_mode/step_btn passes a 2-flop synchroniser (2-clk latency);
//     FSM sees only synced halt_s, mode_s, btn_s.
//   Debounce: counter clears whenever btn_s == deb level.
//     Otherwise it increments; when btn_s has differed for DEB_CYCLES consecutive clks,
//     deb <= btn_s and the counter clears.
//     step_req = 1-clk pulse on deb rising edge; falling edge generates nothing.
//   FSM (halt_s has priority over every other condition):
//     HALT:      !halt_s -> (mode_s ? STEP_WAIT : RUN); else stay.
//     RUN:       halt_s -> HALT; else mode_s -> STEP_WAIT; else stay.
//     STEP_WAIT: halt_s -> HALT; else !mode_s -> RUN; else step_req -> STEP_FIRE.
//     STEP_FIRE: halt_s -> HALT; else -> STEP_WAIT (always exactly one clk).
//   div_cnt: counts 0..RUN_DIV-1 only while state==RUN, wraps to 0.
//     Forced to 0 in any cycle state!=RUN, so every RUN entry restarts the period.
//   cpu_en = (state==STEP_FIRE) | (state==RUN & div_cnt==RUN_DIV-1).
//     Decoded from flops only; no input-to-output combinational path.
//     First RUN pulse is RUN_DIV clks after RUN entry.
//   Leaving RUN on the same edge div_cnt would wrap: the pulse already high that cycle
//     completes; no extra pulse follows.
//   step_req outside STEP_WAIT (HALT, RUN, STEP_FIRE) is dropped, not queued.
//     One press yields at most one pulse.
//   cycle_cnt += 1 on each clk with cpu_en=1; wraps modulo 2^CNT_W; cleared only by rst.
//   cpu_halted = (state==HALT); state port = encoded FSM register.
// TESTING (bench params RUN_DIV=4, DEB_CYCLES=3, CNT_W=4 unless noted)
//   1. rst then halt=1 for 20 clks -> state=00, cpu_halted=1, cpu_en never 1, cycle_cnt=0.
//   2. halt=0, step_mode=0 -> state=01 after 2-3 clks; cpu_en high every 4th clk.
//      After 40 clks in RUN, cycle_cnt=10 (CNT_W=8).
//   3. step_mode=1, step_btn bounces 1,0,1,0 (1-clk each) then holds 1 for 10 clks
//      -> exactly one cpu_en pulse (state 11 for one clk), cycle_cnt=1.
//      Release 10 clks and press again -> cycle_cnt=2.
//   4. RUN, halt=1 when div_cnt=2 -> state=00, no further pulses.
//      halt=0 -> RUN, first pulse exactly 4 clks after state becomes 01.
//   5. STEP_WAIT with halt_s and step_req rising on the same clk -> state=00,
//      no cpu_en pulse, cycle_cnt unchanged.
//   6. 17 pulses with CNT_W=4 -> cycle_cnt=1.
//      rst asserted mid-clk during STEP_FIRE -> cpu_en=0 and cycle_cnt=0 before the next
//      clk edge; state=00.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/halt/single-step sequencer for the board's single-cycle CPU. Instead of
//   a divided CPU clock, the CPU runs on the board clock and is gated by a
//   one-cycle enable pulse (cpu_en). Three operating modes:
//     - free-run : one cpu_en pulse every RUN_DIV clk cycles
//     - halted   : no pulses
//     - step     : one pulse per debounced press of step_btn
//   A count of issued pulses (retired CPU cycles) feeds the 7-segment display.
//
// Parameters
//   RUN_DIV     clk cycles per cpu_en pulse while running (>= 2)
//   DEB_CYCLES  consecutive stable clk cycles before the debounced button
//               level follows the synchronised input (>= 1)
//   CNT_W       width of cycle_cnt
//
// Ports
//   clk         board clock, all flops on rising edge
//   rst         asynchronous, active-high reset
//   halt        raw switch, 1 forces HALT (overrides everything else)
//   step_mode   raw switch, 1 = single-step, 0 = free-run
//   step_btn    raw, bouncing push-button
//   cpu_en      one-clk enable pulse to the CPU
//   cpu_halted  1 while the FSM is in HALT
//   state       FSM register: HALT=00 RUN=01 STEP_WAIT=10 STEP_FIRE=11
//   cycle_cnt   number of cpu_en pulses since reset (wraps)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int RUN_DIV    = 500000,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             step_mode,
  input  logic             step_btn,
  output logic             cpu_en,
  output logic             cpu_halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_STEP_FIRE = 2'b11
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers for the three asynchronous board inputs.
  // Bit order: [0]=halt, [1]=step_mode, [2]=step_btn
  // -------------------------------------------------------------------------
  logic [2:0] raw_in;
  logic [2:0] sync_meta_reg;
  logic [2:0] sync_reg;

  assign raw_in = {step_btn, step_mode, halt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
    end else begin
      sync_meta_reg <= raw_in;
      sync_reg      <= sync_meta_reg;
    end
  end

  logic halt_s;
  logic mode_s;
  logic btn_s;

  assign halt_s = sync_reg[0];
  assign mode_s = sync_reg[1];
  assign btn_s  = sync_reg[2];

  // -------------------------------------------------------------------------
  // Button debounce. The counter tracks how many consecutive cycles btn_s
  // has disagreed with the debounced level; any agreement clears it.
  // -------------------------------------------------------------------------
  logic [DEB_W-1:0] deb_cnt_reg;
  logic             deb_reg;
  logic             deb_d_reg;
  logic             step_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_reg <= '0;
      deb_reg     <= 1'b0;
      deb_d_reg   <= 1'b0;
    end else begin
      deb_d_reg <= deb_reg;
      if (btn_s == deb_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        deb_reg     <= btn_s;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  // One-cycle request on the debounced rising edge only; release is ignored.
  assign step_req = deb_reg & ~deb_d_reg;

  // -------------------------------------------------------------------------
  // Sequencer FSM plus the run-rate divider. The divider only advances while
  // the FSM stays in RUN, and is cleared on every other path so that each
  // RUN entry starts a fresh full period.
  // -------------------------------------------------------------------------
  state_t           state_reg;
  logic [DIV_W-1:0] div_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_HALT;
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= '0;
      case (state_reg)
        ST_HALT: begin
          if (!halt_s) begin
            state_reg <= mode_s ? ST_STEP_WAIT : ST_RUN;
          end
        end
        ST_RUN: begin
          if (halt_s) begin
            state_reg <= ST_HALT;
          end else if (mode_s) begin
            state_reg <= ST_STEP_WAIT;
          end else begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
          end
        end
        ST_STEP_WAIT: begin
          if (halt_s) begin
            state_reg <= ST_HALT;
          end else if (!mode_s) begin
            state_reg <= ST_RUN;
          end else if (step_req) begin
            state_reg <= ST_STEP_FIRE;
          end
        end
        ST_STEP_FIRE: begin
          state_reg <= halt_s ? ST_HALT : ST_STEP_WAIT;
        end
        default: begin
          state_reg <= ST_HALT;
        end
      endcase
    end
  end

  // Decoded purely from flops so no raw input reaches cpu_en combinationally;
  // the async reset of state_reg drops cpu_en without waiting for a clk edge.
  assign cpu_en = (state_reg == ST_STEP_FIRE) |
                  ((state_reg == ST_RUN) && (div_cnt_reg == DIV_LAST));

  assign cpu_halted = (state_reg == ST_HALT);
  assign state      = state_reg;

  // -------------------------------------------------------------------------
  // Retired-cycle counter, wraps naturally at 2^CNT_W.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cycle_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_reg <= '0;
    end else if (cpu_en) begin
      cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//   Scoreboard bench for cpu_run_ctrl. A reference model advances on each
//   rising clk edge from the raw inputs and pushes every predicted cpu_en
//   pulse (edge index + cycle_cnt at that time) into a queue. A monitor on
//   the falling edge pops and compares whenever the DUT raises cpu_en, flags
//   predicted pulses that never came, and compares state / cpu_halted.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int RUN_DIV    = 4;
  localparam int DEB_CYCLES = 3;
  localparam int CNT_W      = 4;
  localparam int CNT_MOD    = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             halt;
  logic             step_mode;
  logic             step_btn;
  logic             cpu_en;
  logic             cpu_halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;

  cpu_run_ctrl #(
    .RUN_DIV   (RUN_DIV),
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .halt      (halt),
    .step_mode (step_mode),
    .step_btn  (step_btn),
    .cpu_en    (cpu_en),
    .cpu_halted(cpu_halted),
    .state     (state),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  typedef struct {
    int edge_no;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   edge_no = 0;
  int   m_state = 0;   // 0 HALT, 1 RUN, 2 STEP_WAIT, 3 STEP_FIRE
  int   m_age   = 0;   // cycles spent in RUN since entry
  int   m_cnt   = 0;
  int   deb_run = 0;
  bit   h1, hs, md1, ms, b1, bs, deb_cur, deb_prev;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_cnt = 0; deb_run = 0;
    h1 = 0; hs = 0; md1 = 0; ms = 0; b1 = 0; bs = 0;
    deb_cur = 0; deb_prev = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int   nxt;
    bit   req;
    exp_t e;
    req = deb_cur && !deb_prev;
    // halt wins; otherwise HALT and RUN both simply follow the mode switch
    if (hs) nxt = 0;
    else begin
      case (m_state)
        0, 1:    nxt = ms ? 2 : 1;
        2:       nxt = !ms ? 1 : (req ? 3 : 2);
        default: nxt = 2;
      endcase
    end
    m_age   = (nxt == 1 && m_state == 1) ? m_age + 1 : 0;
    m_state = nxt;
    if (nxt == 3 || (nxt == 1 && (m_age % RUN_DIV) == RUN_DIV - 1)) begin
      e.edge_no = edge_no;
      e.cnt     = m_cnt;
      exp_q.push_back(e);
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end
    // debounced level follows after DEB_CYCLES disagreeing cycles in a row
    deb_prev = deb_cur;
    if (bs != deb_cur) begin
      deb_run++;
      if (deb_run == DEB_CYCLES) begin
        deb_cur = bs;
        deb_run = 0;
      end
    end else begin
      deb_run = 0;
    end
    hs = h1; h1 = halt;
    ms = md1; md1 = step_mode;
    bs = b1; b1 = step_btn;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      if (rst) model_reset();
      else     model_step();
    end
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_no) begin
          checks++;
          errors++;
          $display("FAIL missed_pulse: cpu_en low at edge %0d, expected high", exp_q[0].edge_no);
          void'(exp_q.pop_front());
        end
        chk("state", int'(state), m_state);
        chk("cpu_halted", int'(cpu_halted), int'(m_state == 0));
        if (cpu_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: cpu_en high at edge %0d, expected low", edge_no);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_edge", edge_no, e.edge_no);
            chk("pulse_cycle_cnt", int'(cycle_cnt), e.cnt);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (m_state == s) break;
      @(negedge clk);
    end
    if (m_state != s) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, state %0d, expected %0d", name, m_state, s);
    end
  endtask

  task automatic press(input int hold);
    step_btn = 1'b1;
    tick(hold);
    step_btn = 1'b0;
    tick(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int base;
    int entry;
    int seen;

    rst = 1'b1; halt = 1'b1; step_mode = 1'b0; step_btn = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_cpu_halted", int'(cpu_halted), 1);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_cycle_cnt", int'(cycle_cnt), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // 1: held in HALT
    tick(20);
    chk("halt_cycle_cnt", int'(cycle_cnt), 0);

    // 2: free run, one pulse per RUN_DIV clks
    halt = 1'b0;
    wait_state(1, 10, "enter_run");
    repeat (40) @(negedge clk);
    chk("run40_cycle_cnt", int'(cycle_cnt), 10);

    // 4: halt mid-period, then resume and time the first pulse
    for (int i = 0; i < 8 && (m_age % RUN_DIV) != 2; i++) @(negedge clk);
    halt = 1'b1;
    wait_state(0, 10, "enter_halt");
    tick(8);
    chk("halted_cycle_cnt", int'(cycle_cnt), m_cnt);
    halt = 1'b0;
    wait_state(1, 10, "reenter_run");
    entry = edge_no;
    seen  = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (cpu_en) seen = 1;
      else @(negedge clk);
    end
    chk("first_pulse_offset", edge_no - entry, RUN_DIV - 1);

    // 3: single step with a bouncy press
    step_mode = 1'b1;
    wait_state(2, 10, "enter_step_wait");
    tick(4);
    base = m_cnt;
    step_btn = 1'b1; tick(1);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1; tick(1);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1; tick(10);
    step_btn = 1'b0; tick(10);
    chk("step1_cycle_cnt", int'(cycle_cnt), (base + 1) % CNT_MOD);
    press(10);
    chk("step2_cycle_cnt", int'(cycle_cnt), (base + 2) % CNT_MOD);

    // 5: halt_s and step_req land on the same clk
    base = m_cnt;
    step_btn = 1'b1;
    tick(3);
    halt = 1'b1;
    tick(10);
    chk("halt_vs_step_state", int'(state), 0);
    chk("halt_vs_step_cycle_cnt", int'(cycle_cnt), base);
    step_btn = 1'b0;
    tick(6);

    // random mix of switch changes and bouncing presses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(39) == 0) halt = ~halt;
      if ($urandom_range(24) == 0) step_mode = ~step_mode;
      if ($urandom_range(7) == 0)  step_btn = ~step_btn;
      @(negedge clk);
    end

    // 6: wrap of cycle_cnt after 17 pulses, then reset during STEP_FIRE
    @(posedge clk);
    #2 rst = 1'b1;
    halt = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_state(1, 10, "run_after_rst");
    repeat (17 * RUN_DIV) @(negedge clk);
    chk("wrap_cycle_cnt", int'(cycle_cnt), 1);
    step_mode = 1'b1;
    wait_state(2, 10, "step_wait_before_rst");
    step_btn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (m_state == 3) seen = 1;
    end
    chk("reached_step_fire", seen, 1);
    chk("fire_cpu_en", int'(cpu_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("midclk_rst_cpu_en", int'(cpu_en), 0);
    chk("midclk_rst_cycle_cnt", int'(cycle_cnt), 0);
    chk("midclk_rst_state", int'(state), 0);
    step_btn = 1'b0; halt = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick(6);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
